// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes,
// funct codes and datapath select codes.
package mc_ctrl_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_R_EXEC   = 4'd2;
  localparam logic [3:0] S_R_WB     = 4'd3;
  localparam logic [3:0] S_I_EXEC   = 4'd4;
  localparam logic [3:0] S_I_WB     = 4'd5;
  localparam logic [3:0] S_MEM_ADDR = 4'd6;
  localparam logic [3:0] S_MEM_RD   = 4'd7;
  localparam logic [3:0] S_MEM_WB   = 4'd8;
  localparam logic [3:0] S_MEM_WR   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_HALT     = 4'd12;

  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SYSCALL = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_SLT   = 3'd4;
  localparam logic [2:0] ALU_FUNCT = 3'd7;

  localparam logic [1:0] SRCB_REG   = 2'd0;
  localparam logic [1:0] SRCB_4     = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMMSH = 2'd3;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  function automatic logic funct_ok(input logic [5:0] fn);
    return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_wd.sv
// Memory-wait watchdog: counts consecutive not-ready cycles while enabled and
// flags expiry on the MAX_WAIT-th such cycle. MAX_WAIT = 0 disables it.
module mem_watchdog #(
  parameter int MAX_WAIT = 16,
  parameter int WAIT_W   = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic ready_i,
  output logic expired_o
);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb cnt_d = (!en_i || ready_i) ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // A ready in the expiry cycle means the transfer completes instead.
  generate
    if (MAX_WAIT == 0) begin : g_off
      logic unused_cnt;
      assign unused_cnt = ^cnt_q;
      assign expired_o  = 1'b0;
    end else begin : g_on
      assign expired_o = en_i && !ready_i && (cnt_q == WAIT_W'(MAX_WAIT - 1));
    end
  endgenerate

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM with memory ready handshake and watchdog.
// Optional macro ILLEGAL_TRAP_EN: unknown opcode/funct traps to HALT with illegal.
module mc_ctrl_fsm import mc_ctrl_pkg::*; #(
  parameter int INSTR_W  = 32,
  parameter int MAX_WAIT = 16,
  parameter int WAIT_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               mem_ready,
  input  logic               zero,
  output logic               pc_en,
  output logic               ir_write,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               ext_zero,
  output logic [2:0]         alu_op,
  output logic [1:0]         pc_src,
  output logic               halted,
  output logic               bus_err,
  output logic               illegal,
  output logic [3:0]         state_o
);

  logic [3:0] state_q, state_d;
  logic       halted_q, halted_d, bus_err_q, bus_err_d;
  logic [5:0] op;
  logic       mem_st, wd_exp;
  logic       unused_instr;

  assign op           = instr[INSTR_W-1 -: 6];
  assign unused_instr = ^instr[INSTR_W-7:0];
  assign mem_st       = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

  mem_watchdog #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) u_wd (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (mem_st),
    .ready_i  (mem_ready),
    .expired_o(wd_exp)
  );

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  always_comb begin
    state_d   = state_q;
    halted_d  = halted_q;
    bus_err_d = bus_err_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_RTYPE: begin
`ifdef ILLEGAL_TRAP_EN
            if (funct_ok(instr[5:0])) state_d = S_R_EXEC;
            else begin state_d = S_HALT; illegal_d = 1'b1; end
`else
            state_d = S_R_EXEC;
`endif
          end
          OP_LW, OP_SW:              state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:            state_d = S_BRANCH;
          OP_ADDI, OP_ORI, OP_SLTI:  state_d = S_I_EXEC;
          OP_J:                      state_d = S_JUMP;
          OP_SYSCALL: begin state_d = S_HALT; halted_d = 1'b1; end
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_d = S_HALT; illegal_d = 1'b1;
`else
            state_d = S_FETCH;
`endif
          end
        endcase
      end
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      S_MEM_ADDR: state_d = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
    if (wd_exp) begin
      state_d   = S_HALT;
      halted_d  = 1'b1;
      bus_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      halted_q  <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      bus_err_q <= bus_err_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    pc_en = 1'b0; ir_write = 1'b0; iord = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    mem_to_reg = 1'b0; reg_dst = 1'b0; reg_write = 1'b0; alu_src_a = 1'b0;
    alu_src_b = SRCB_REG; ext_zero = 1'b0; alu_op = ALU_ADD; pc_src = PC_ALU;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1; alu_src_b = SRCB_4;
        pc_en = mem_ready; ir_write = mem_ready;
      end
      S_DECODE:   alu_src_b = SRCB_IMMSH;
      S_R_EXEC:   begin alu_src_a = 1'b1; alu_op = ALU_FUNCT; end
      S_R_WB:     begin reg_write = 1'b1; reg_dst = 1'b1; end
      S_I_EXEC: begin
        alu_src_a = 1'b1; alu_src_b = SRCB_IMM;
        if (op == OP_ORI) begin alu_op = ALU_OR; ext_zero = 1'b1; end
        else if (op == OP_SLTI) alu_op = ALU_SLT;
      end
      S_I_WB:     reg_write = 1'b1;
      S_MEM_ADDR: begin alu_src_a = 1'b1; alu_src_b = SRCB_IMM; end
      S_MEM_RD:   begin mem_read = 1'b1; iord = 1'b1; end
      S_MEM_WB:   begin reg_write = 1'b1; mem_to_reg = 1'b1; end
      S_MEM_WR:   begin mem_write = 1'b1; iord = 1'b1; end
      S_BRANCH: begin
        alu_src_a = 1'b1; alu_op = ALU_SUB; pc_src = PC_ALUOUT;
        pc_en = (op == OP_BNE) ? !zero : zero;
      end
      S_JUMP:     begin pc_en = 1'b1; pc_src = PC_JUMP; end
      default: ;
    endcase
    // The reset state is FETCH; keep its strobes quiet while reset is held.
    if (!rst_n) begin
      pc_en = 1'b0; ir_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
    end
  end

  assign halted  = halted_q;
  assign bus_err = bus_err_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench: each instruction is expanded into the expected per-cycle
// trace (state, outputs, flags) and replayed against the FSM with random waits.
module tb_mc_ctrl_fsm;
  import mc_ctrl_pkg::*;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic mem_ready = 1'b0, zero = 1'b0;
  logic pc_en, ir_write, iord, mem_read, mem_write, mem_to_reg, reg_dst, reg_write;
  logic alu_src_a, ext_zero, halted, bus_err, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_op;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.INSTR_W(32), .MAX_WAIT(16), .WAIT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .zero(zero),
    .pc_en(pc_en), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_zero(ext_zero), .alu_op(alu_op), .pc_src(pc_src), .halted(halted),
    .bus_err(bus_err), .illegal(illegal), .state_o(state_o)
  );

  logic [16:0] obs;
  assign obs = {pc_en, ir_write, iord, mem_read, mem_write, mem_to_reg, reg_dst, reg_write,
                alu_src_a, alu_src_b, ext_zero, alu_op, pc_src};

  int checks = 0, errors = 0;

  typedef struct {
    logic [31:0] ins; logic [3:0] st; bit rdy; bit z;
    logic [16:0] v; logic [16:0] m; logic [2:0] fl;
  } cyc_t;
  cyc_t q[$];
  logic [2:0]  fl_now;   // expected {halted, bus_err, illegal}
  logic [31:0] cur_ins;
  logic [16:0] M_STB, M_FET, M_EX, M_IEX, M_WB, M_MEM, M_MWB, M_BR, M_J;

  function automatic logic [16:0] pk(int pe, int irw, int io, int mr, int mw, int m2r,
                                     int rd, int rw, int a, int b, int ez, int op, int ps);
    return {1'(pe), 1'(irw), 1'(io), 1'(mr), 1'(mw), 1'(m2r), 1'(rd), 1'(rw),
            1'(a), 2'(b), 1'(ez), 3'(op), 2'(ps)};
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [3:0] st, input bit rdy, input bit z,
                      input logic [16:0] v, input logic [16:0] m);
    cyc_t c;
    c.ins = cur_ins; c.st = st; c.rdy = rdy; c.z = z; c.v = v; c.m = m; c.fl = fl_now;
    q.push_back(c);
  endtask

  task automatic push_halt(input int n);
    repeat (n) push(S_HALT, rb(), rb(), '0, M_STB);
  endtask

  // A memory phase: w not-ready cycles then ready, or watchdog expiry at 16 waits.
  task automatic mem_phase(input logic [3:0] st, input int w, input logic [16:0] vw,
                           input logic [16:0] vr, input logic [16:0] m, output bit died);
    died = 1'b0;
    for (int i = 0; i < w && i < 16; i++) push(st, 1'b0, rb(), vw, m);
    if (w >= 16) begin
      died = 1'b1; fl_now = 3'b110; push_halt(2);
    end else push(st, 1'b1, rb(), vr, m);
  endtask

  task automatic add_instr(input logic [31:0] ins, input int fd, input int md, input bit z);
    bit died;
    logic [5:0] op;
    op = ins[31:26];
    cur_ins = ins;
    mem_phase(S_FETCH, fd, pk(0,0,0,1,0,0,0,0,0,1,0,0,0), pk(1,1,0,1,0,0,0,0,0,1,0,0,0),
              M_FET, died);
    if (died) return;
    push(S_DECODE, rb(), rb(), pk(0,0,0,0,0,0,0,0,0,3,0,0,0), M_EX);
    case (op)
      6'h00: begin
`ifdef ILLEGAL_TRAP_EN
        if (!(ins[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A})) begin
          fl_now = 3'b001; push_halt(3); return;
        end
`endif
        push(S_R_EXEC, rb(), rb(), pk(0,0,0,0,0,0,0,0,1,0,0,7,0), M_EX);
        push(S_R_WB,   rb(), rb(), pk(0,0,0,0,0,0,1,1,0,0,0,0,0), M_WB);
      end
      6'h23, 6'h2B: begin
        push(S_MEM_ADDR, rb(), rb(), pk(0,0,0,0,0,0,0,0,1,2,0,0,0), M_EX);
        if (op == 6'h23) begin
          mem_phase(S_MEM_RD, md, pk(0,0,1,1,0,0,0,0,0,0,0,0,0), pk(0,0,1,1,0,0,0,0,0,0,0,0,0),
                    M_MEM, died);
          if (!died) push(S_MEM_WB, rb(), rb(), pk(0,0,0,0,0,1,0,1,0,0,0,0,0), M_MWB);
        end else
          mem_phase(S_MEM_WR, md, pk(0,0,1,0,1,0,0,0,0,0,0,0,0), pk(0,0,1,0,1,0,0,0,0,0,0,0,0),
                    M_MEM, died);
      end
      6'h04, 6'h05:
        push(S_BRANCH, rb(), z, pk(int'(z ^ (op == 6'h05)),0,0,0,0,0,0,0,1,0,0,1,1), M_BR);
      6'h08, 6'h0D, 6'h0A: begin
        push(S_I_EXEC, rb(), rb(), pk(0,0,0,0,0,0,0,0,1,2, int'(op == 6'h0D),
             (op == 6'h0D) ? 3 : (op == 6'h0A) ? 4 : 0, 0), M_IEX);
        push(S_I_WB, rb(), rb(), pk(0,0,0,0,0,0,0,1,0,0,0,0,0), M_WB);
      end
      6'h02: push(S_JUMP, rb(), rb(), pk(1,0,0,0,0,0,0,0,0,0,0,0,2), M_J);
      6'h0C: begin fl_now = 3'b100; push_halt(20); end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        fl_now = 3'b001; push_halt(3);
`endif
      end
    endcase
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mem_ready = 1'b1; zero = rb();
    #1;
    checks++;
    if (state_o !== 4'd0 || (obs & M_STB) !== 17'd0 || {halted, bus_err, illegal} !== 3'b000) begin
      errors++;
      $display("FAIL reset: state %0d strobes %h flags %b, want state 0 strobes 0 flags 000",
               state_o, obs & M_STB, {halted, bus_err, illegal});
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0; fl_now = 3'b000;
  endtask

  task automatic run_trace(input string name);
    cyc_t c;
    bit desync = 1'b0;
    while (q.size() > 0) begin
      c = q.pop_front();
      instr = c.ins; mem_ready = c.rdy; zero = c.z;
      #1;
      checks++;
      if (state_o !== c.st) begin
        errors++; desync = 1'b1;
        $display("FAIL %s state: got %0d want %0d", name, state_o, c.st);
        q.delete();
      end
      checks++;
      if ((obs & c.m) !== (c.v & c.m)) begin
        errors++;
        $display("FAIL %s outputs in state %0d: got %h want %h (mask %h)",
                 name, c.st, obs & c.m, c.v & c.m, c.m);
      end
      checks++;
      if ({halted, bus_err, illegal} !== c.fl) begin
        errors++;
        $display("FAIL %s flags in state %0d: got %b want %b", name, c.st,
                 {halted, bus_err, illegal}, c.fl);
      end
      @(negedge clk);
    end
    if (desync) do_reset();
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_add();
    add_instr(32'h00221820, 0, 0, 1'b0);
    run_trace("add");
  endtask

  task automatic test_lw();
    add_instr(32'h8C220004, 0, 3, 1'b0);
    add_instr(32'hAC220008, 2, 1, 1'b0);
    run_trace("lw_sw");
  endtask

  task automatic test_branch();
    add_instr(32'h10220003, 0, 0, 1'b1);
    add_instr(32'h14220003, 0, 0, 1'b1);
    add_instr(32'h14220003, 1, 0, 1'b0);
    add_instr(32'h10220003, 0, 0, 1'b0);
    run_trace("branch");
  endtask

  task automatic test_halt();
    add_instr(32'h30000000, 0, 0, 1'b0);
    run_trace("halt");
    do_reset();
    add_instr(32'h08000010, 0, 0, 1'b0);
    run_trace("after_halt");
  endtask

  task automatic test_watchdog();
    add_instr(32'h00221820, 16, 0, 1'b0);
    run_trace("wd_fetch_expire");
    do_reset();
    add_instr(32'h00221820, 15, 0, 1'b0);
    run_trace("wd_fetch_ready_last");
    add_instr(32'h8C220004, 0, 16, 1'b0);
    run_trace("wd_memrd_expire");
    do_reset();
    add_instr(32'hAC220004, 15, 15, 1'b0);
    add_instr(32'hAC220004, 0, 16, 1'b0);
    run_trace("wd_memwr");
    do_reset();
  endtask

  task automatic test_illegal();
`ifdef ILLEGAL_TRAP_EN
    add_instr(32'hFC000000, 0, 0, 1'b0);
    run_trace("illegal_op");
    do_reset();
    add_instr(32'h0022183F, 0, 0, 1'b0);
    run_trace("illegal_funct");
    do_reset();
`else
    add_instr(32'hFC000000, 0, 0, 1'b0);
    add_instr(32'h00221820, 0, 0, 1'b0);
    run_trace("nop_op");
`endif
  endtask

  task automatic test_reset_mid();
    add_instr(32'h8C220004, 0, 5, 1'b0);
    while (q.size() > 4) void'(q.pop_back());
    run_trace("reset_mid_pre");
    mem_ready = 1'b0;
    #1;
    checks++;
    if (mem_read !== 1'b1 || iord !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_memrd: mem_read %b iord %b want 1 1", mem_read, iord);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (state_o !== 4'd0 || (obs & M_STB) !== 17'd0) begin
      errors++;
      $display("FAIL reset_mid: state %0d strobes %h want 0 0", state_o, obs & M_STB);
    end
    @(negedge clk);
    rst_n = 1'b1; fl_now = 3'b000;
    add_instr(32'h00221820, 0, 0, 1'b0);
    run_trace("reset_mid_post");
  endtask

  task automatic test_random();
    logic [5:0] ol [9];
    logic [5:0] fnl [5];
    logic [31:0] ins;
    int fd, md;
    ol  = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h0A, 6'h02};
    fnl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    repeat (80) begin
      ins = $urandom;
      ins[31:26] = ol[$urandom_range(0, 8)];
      if (ins[31:26] == 6'h00) ins[5:0] = fnl[$urandom_range(0, 4)];
      fd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
      md = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
      add_instr(ins, fd, md, rb());
      run_trace("random");
    end
  endtask

  initial begin
    fl_now  = 3'b000;
    cur_ins = '0;
    M_STB = pk(1,1,0,1,1,0,0,1,0,0,0,0,0);
    M_FET = pk(1,1,1,1,1,0,0,1,1,3,0,7,3);
    M_EX  = pk(1,1,0,1,1,0,0,1,1,3,0,7,0);
    M_IEX = pk(1,1,0,1,1,0,0,1,1,3,1,7,0);
    M_WB  = pk(1,1,0,1,1,0,1,1,0,0,0,0,0);
    M_MEM = pk(1,1,1,1,1,0,0,1,0,0,0,0,0);
    M_MWB = pk(1,1,0,1,1,1,1,1,0,0,0,0,0);
    M_BR  = pk(1,1,0,1,1,0,0,1,1,3,0,7,3);
    M_J   = pk(1,1,0,1,1,0,0,1,0,0,0,0,3);
    test_reset();
    test_add();
    test_lw();
    test_branch();
    test_halt();
    test_watchdog();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multi-cycle control unit for the MIPS datapath; the sequential successor to the single-cycle main decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states against a shared memory with a ready handshake.
- Instruction set widened to bne, ori, slti; syscall becomes a sticky synthesizable HALT state rather than a simulation stop.
- Adds a memory-wait watchdog.

Parameters:
INSTR_W, 32, instruction register width (opcode = instr[INSTR_W-1 -: 6], funct = instr[5:0])
MAX_WAIT, 16, memory cycles allowed without mem_ready before bus error
WAIT_W, 5, watchdog counter width; must satisfy 2^WAIT_W > MAX_WAIT

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr  in  INSTR_W  instruction register contents
mem_ready  in  1  memory completes current read/write this cycle
zero  in  1  ALU zero flag
pc_en  out  1  PC register load
ir_write  out  1  instruction register load
iord  out  1  memory address: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
mem_to_reg  out  1  write-back source: 1 = memory data
reg_dst  out  1  destination: 1 = rd, 0 = rt
reg_write  out  1  register file write
alu_src_a  out  1  0 = PC, 1 = reg A
alu_src_b  out  2  0 = reg B, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm << 2
ext_zero  out  1  immediate zero-extended (ori) instead of sign-extended
alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 7 FUNCT (ALU decoder uses funct)
pc_src  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
halted  out  1  sticky; syscall executed
bus_err  out  1  sticky; watchdog expired
illegal  out  1  sticky; illegal instruction (see Optional Feature)
state_o  out  4  current state encoding, for debug

Behaviour:
- Reset (async, rst_n = 0): state = FETCH, wait counter = 0, halted/bus_err/illegal = 0. All strobes deassert combinationally while rst_n is low. Reset mid-instruction aborts it with no write strobes.
- Outputs are Moore decodes of state, with two exceptions:
  - FETCH: ir_write and pc_en are gated by mem_ready.
  - BRANCH: pc_en = zero (beq) or !zero (bne).
- FETCH: mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 1, alu_op = ADD, pc_src = 0. Holds until mem_ready, then writes IR and PC+4 -> DECODE.
- DECODE: alu_src_a = 0, alu_src_b = 3, alu_op = ADD (branch target into ALUOut). Next state by opcode:
  - 0x00 -> R_EXEC
  - 0x23 / 0x2B -> MEM_ADDR
  - 0x04 / 0x05 -> BRANCH
  - 0x08 / 0x0D / 0x0A -> I_EXEC
  - 0x02 -> JUMP
  - 0x0C -> HALT
  - other -> see Optional Feature
- R_EXEC: alu_src_a = 1, alu_src_b = 0, alu_op = FUNCT -> R_WB.
- R_WB: reg_write = 1, reg_dst = 1 -> FETCH.
- I_EXEC: alu_src_a = 1, alu_src_b = 2; alu_op ADD (addi), OR with ext_zero = 1 (ori), SLT (slti) -> I_WB.
- I_WB: reg_write = 1, reg_dst = 0 -> FETCH.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 2, alu_op = ADD -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_read = 1, iord = 1; on mem_ready -> MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0 -> FETCH.
- MEM_WR: mem_write = 1, iord = 1; on mem_ready -> FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 0, alu_op = SUB, pc_src = 1 -> FETCH.
- JUMP: pc_en = 1, pc_src = 2 -> FETCH.
- HALT: all strobes 0, halted = 1; remains until reset.
- Watchdog (FETCH, MEM_RD, MEM_WR):
  - Counter increments each cycle mem_ready = 0 and clears on mem_ready or state exit.
  - When the counter reaches MAX_WAIT with mem_ready still 0 -> HALT with bus_err = 1; halted also = 1.
  - mem_ready in the same cycle as expiry: the transfer wins.
  - MAX_WAIT = 0 disables the watchdog.
- mem_ready outside memory states is ignored.

Optional Feature:
ILLEGAL_TRAP_EN.
- Defined: an unknown opcode, or an unknown funct for opcode 0x00 (anything other than 0x20/0x22/0x24/0x25/0x2A), in DECODE -> HALT with illegal = 1; halted stays 0.
- Undefined: the instruction executes as a NOP (DECODE -> FETCH) and the illegal port is tied 0.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum (4-bit; FETCH = 0)
  - opcode and funct localparams
  - alu_op, alu_src_b and pc_src codes
- Sub-module mem_watchdog (counter, clear/enable, expiry flag, parameter MAX_WAIT) is natural and reusable by the cache controller.

Test Plan:
- add $3,$1,$2 with mem_ready = 1 each fetch -> states FETCH, DECODE, R_EXEC, R_WB (4 cycles); reg_write = 1 and reg_dst = 1 only in R_WB.
- lw with mem_ready delayed 3 cycles in MEM_RD -> mem_read and iord held 3 cycles, then MEM_WB with mem_to_reg = 1; 8 cycles total.
- beq with zero = 1, then bne with zero = 1 -> pc_en = 1 and pc_src = 1 in BRANCH for beq; pc_en = 0 for bne.
- Instruction 0x30000000 (opcode 0x0C) -> HALT; halted = 1 and all strobes 0 for 20 further cycles; rst_n pulse returns state_o = 0.
- mem_ready held 0 in FETCH with MAX_WAIT = 16 -> bus_err = 1 and halted = 1 after exactly 16 wait cycles; a mem_ready on cycle 16 completes the fetch instead.
- Opcode 0x3F with ILLEGAL_TRAP_EN defined -> HALT, illegal = 1. Without the macro -> DECODE then FETCH, no strobes.
